// File: rtl/seq_normalizer.sv
// seq_normalizer: sequential leading-one normalizer.
// A word is accepted in IDLE and shifted left one bit per clock in SHIFT until
// its MSB is set. DONE then presents the normalized word and the shift count
// until the consumer takes them. Recovery: data_in << shift_amt == data_out.
// All result outputs are registered; in_ready is decoded from the state.
module seq_normalizer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic [CNT_W-1:0] shift_amt,
  output logic             zero
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [WIDTH-1:0] WORD_ZERO = {WIDTH{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_STEP  = CNT_W'(1);

  logic [1:0]       state_r;
  logic [WIDTH-1:0] work_r;
  logic [CNT_W-1:0] count_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] data_out_r;
  logic [CNT_W-1:0] shift_amt_r;
  logic             zero_r;

  // Ready only while idle; held low during reset so nothing is accepted then.
  assign in_ready  = (state_r == ST_IDLE) && !rst;
  assign out_valid = out_valid_r;
  assign data_out  = data_out_r;
  assign shift_amt = shift_amt_r;
  assign zero      = zero_r;

  // Control FSM plus work/count datapath and registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      work_r      <= WORD_ZERO;
      count_r     <= CNT_ZERO;
      out_valid_r <= 1'b0;
      data_out_r  <= WORD_ZERO;
      shift_amt_r <= CNT_ZERO;
      zero_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          // in_ready is implied here because rst is low and state is IDLE.
          if (in_valid) begin
            work_r  <= data_in;
            count_r <= CNT_ZERO;
            zero_r  <= (data_in == WORD_ZERO);
            state_r <= ST_SHIFT;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          if (work_r == WORD_ZERO) begin
            // All-zero word has no leading one; report it without shifting.
            zero_r      <= 1'b1;
            data_out_r  <= WORD_ZERO;
            shift_amt_r <= CNT_ZERO;
            out_valid_r <= 1'b1;
            state_r     <= ST_DONE;
          end else if (work_r[WIDTH-1]) begin
            data_out_r  <= work_r;
            shift_amt_r <= count_r;
            out_valid_r <= 1'b1;
            state_r     <= ST_DONE;
          end else begin
            // At most WIDTH-1 shifts happen, so the count cannot wrap.
            work_r  <= {work_r[WIDTH-2:0], 1'b0};
            count_r <= count_r + CNT_STEP;
            state_r <= ST_SHIFT;
          end
        end
        ST_DONE: begin
          // Outputs hold untouched until the consumer takes the result.
          if (out_ready) begin
            out_valid_r <= 1'b0;
            state_r     <= ST_IDLE;
          end else begin
            state_r <= ST_DONE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_normalizer.sv
// Self-checking bench for seq_normalizer (WIDTH=4).
// Expected results come from a table or a leading-zero model, are queued on
// accept and compared when the DUT completes an output handshake.
module tb_seq_normalizer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] data_in;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] data_out;
  logic [1:0] shift_amt;
  logic       zero;

  typedef struct {
    logic [3:0] din;
    logic [3:0] dout;
    logic [1:0] amt;
    logic       zero;
    int         lat;
  } vec_t;

  vec_t sb_q[$];
  vec_t mon_e;
  vec_t vecs[8];

  int checks  = 0;
  int errors  = 0;
  int acc_cnt = 0;
  int out_cnt = 0;
  int exp_acc = 0;
  int exp_out = 0;
  logic [3:0] rec;

  seq_normalizer #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .shift_amt (shift_amt),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Independent model: count leading zeros from the MSB.
  function automatic vec_t model(input logic [3:0] d);
    vec_t r;
    int k;
    r.din = d;
    if (d == 4'b0000) begin
      r.dout = 4'b0000; r.amt = 2'd0; r.zero = 1'b1; r.lat = 1;
    end else begin
      k = 0;
      while (d[3-k] == 1'b0) k++;
      r.dout = d << k; r.amt = 2'(k); r.zero = 1'b0; r.lat = k + 1;
    end
    return r;
  endfunction

  // Scoreboard monitor: count accepts, pop and compare on each output handshake.
  always @(posedge clk) begin
    if (!rst && in_valid && in_ready) acc_cnt++;
    if (!rst && out_valid && out_ready) begin
      out_cnt++;
      if (sb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_unexpected actual=output expected=none data_out=%0h", data_out);
      end else begin
        mon_e = sb_q.pop_front();
        chk("sb_data_out", data_out, mon_e.dout);
        chk("sb_shift_amt", shift_amt, mon_e.amt);
        chk("sb_zero", zero, mon_e.zero);
        rec = mon_e.din << shift_amt;
        chk("sb_recover", data_out, rec);
        chk("sb_msb", data_out[3], (mon_e.din != 4'b0000));
      end
    end
  end

  // Send one word, measure latency, stall the consumer, then take the result.
  task automatic do_word(input vec_t v, input int stall);
    int n;
    in_valid = 1'b1;
    data_in  = v.din;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("accept_ready", in_ready, 1'b1);
    sb_q.push_back(v);
    exp_acc++;
    exp_out++;
    @(posedge clk); #1;
    // Keep in_valid high with a different word: must be ignored while busy.
    data_in = ~v.din;
    n = 0;
    while (!out_valid && n < 20) begin
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1; n++;
    end
    out_ready = 1'b0;
    chk("latency", n, v.lat);
    chk("busy_in_ready", in_ready, 1'b0);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_data", data_out, v.dout);
      chk("hold_amt", shift_amt, v.amt);
      chk("hold_zero", zero, v.zero);
      chk("hold_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("release_valid", out_valid, 1'b0);
    chk("release_in_ready", in_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{din: 4'b1011, dout: 4'b1011, amt: 2'd0, zero: 1'b0, lat: 1};
    vecs[1] = '{din: 4'b0011, dout: 4'b1100, amt: 2'd2, zero: 1'b0, lat: 3};
    vecs[2] = '{din: 4'b0001, dout: 4'b1000, amt: 2'd3, zero: 1'b0, lat: 4};
    vecs[3] = '{din: 4'b0000, dout: 4'b0000, amt: 2'd0, zero: 1'b1, lat: 1};
    vecs[4] = '{din: 4'b0100, dout: 4'b1000, amt: 2'd1, zero: 1'b0, lat: 2};
    vecs[5] = '{din: 4'b1000, dout: 4'b1000, amt: 2'd0, zero: 1'b0, lat: 1};
    vecs[6] = '{din: 4'b0110, dout: 4'b1100, amt: 2'd1, zero: 1'b0, lat: 2};
    vecs[7] = '{din: 4'b0010, dout: 4'b1000, amt: 2'd2, zero: 1'b0, lat: 3};

    // Reset state.
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; data_in = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_data_out", data_out, 4'b0000);
    chk("rst_shift_amt", shift_amt, 2'd0);
    chk("rst_zero", zero, 1'b0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1'b1);

    // Table vectors.
    for (int i = 0; i < 8; i++) do_word(vecs[i], (i % 3));

    // Backpressure: five stalled cycles in DONE.
    do_word(vecs[1], 5);

    // Reset mid-SHIFT with 0001: word discarded, no output.
    @(posedge clk); #1;
    in_valid = 1'b1; data_in = 4'b0001;
    @(posedge clk); #1;
    exp_acc++;
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("midshift_busy", in_ready, 1'b0);
    rst = 1'b1;
    #1;
    chk("midshift_rst_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_data_out", data_out, 4'b0000);
    chk("midrst_shift_amt", shift_amt, 2'd0);
    chk("midrst_zero", zero, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b1);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("midrst_no_output", out_valid, 1'b0);
    end
    out_ready = 1'b0;

    // Exhaustive sweep with random consumer stalls.
    for (int v = 0; v < 16; v++) do_word(model(4'(v)), $urandom_range(0, 3));

    repeat (3) @(posedge clk);
    #1;
    chk("accept_count", acc_cnt, exp_acc);
    chk("output_count", out_cnt, exp_out);
    chk("sb_empty", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
